// File: rtl/load_store_unit.sv
// Word-port load/store unit: turns RV32I byte-addressed loads/stores into word accesses,
// doing read-modify-write for SB/SH and flagging misaligned, illegal or out-of-range requests.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] mem_Addr,
    output logic [31:0] mem_Wd,
    output logic        mem_Wen,
    output logic        mem_Ren,
    input  logic [31:0] mem_Rd,
    output logic [2:0]  dbg_state_o
);

    // Handshake: a request transfers on the rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and the response is a single rsp_valid cycle.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_MERGE = 3'd2;
    localparam logic [2:0] ST_WR    = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic        f3_ok;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] st_merged;

    assign accept = req_valid && req_ready;

    always_comb begin
        f3_ok = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !req_we;
            default:                f3_ok = 1'b0;
        endcase
    end

    assign misaligned   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                          (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    assign out_of_range = {2'b00, req_addr[31:2]} >= MEM_WORDS;
    assign req_err      = !f3_ok || misaligned || out_of_range;

    always_comb begin
        ld_byte = mem_Rd[7:0];
        case (off_q)
            2'd0: ld_byte = mem_Rd[7:0];
            2'd1: ld_byte = mem_Rd[15:8];
            2'd2: ld_byte = mem_Rd[23:16];
            2'd3: ld_byte = mem_Rd[31:24];
            default: ld_byte = mem_Rd[7:0];
        endcase
    end

    assign ld_half = off_q[1] ? mem_Rd[31:16] : mem_Rd[15:0];

    always_comb begin
        ld_ext = mem_Rd;
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_Rd;
        endcase
    end

    // Only SB/SH reach MERGE as stores, so funct3[0] alone picks byte vs halfword.
    always_comb begin
        st_merged = mem_Rd;
        if (!f3_q[0]) begin
            case (off_q)
                2'd0: st_merged[7:0]   = wd_q[7:0];
                2'd1: st_merged[15:8]  = wd_q[7:0];
                2'd2: st_merged[23:16] = wd_q[7:0];
                2'd3: st_merged[31:24] = wd_q[7:0];
                default: st_merged = mem_Rd;
            endcase
        end else if (off_q[1]) begin
            st_merged[31:16] = wd_q[15:0];
        end else begin
            st_merged[15:0] = wd_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        off_d   = off_q;
        we_d    = we_q;
        f3_d    = f3_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = {2'b00, req_addr[31:2]};
                    off_d   = req_addr[1:0];
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    wd_d    = req_wdata;
                    rdata_d = 32'd0;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (req_we && req_funct3[1:0] == 2'b10) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: state_d = ST_MERGE;
            ST_MERGE: begin
                if (we_q) begin
                    wd_d    = st_merged;
                    state_d = ST_WR;
                end else begin
                    rdata_d = ld_ext;
                    state_d = ST_RESP;
                end
            end
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'd0;
            off_q   <= 2'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            wd_q    <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode straight from state, so an async reset drops them in the same instant.
    assign req_ready   = (state_q == ST_IDLE);
    assign mem_Ren     = (state_q == ST_RD);
    assign mem_Wen     = (state_q == ST_WR);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_error   = (state_q == ST_RESP) && err_q;
    assign rsp_rdata   = rdata_q;
    assign mem_Addr    = addr_q;
    assign mem_Wd      = wd_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized loads/stores
// against a byte-level reference model of memory contents and timing.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_Addr;
    logic [31:0] mem_Wd;
    logic        mem_Wen;
    logic        mem_Ren;
    logic [31:0] mem_Rd;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_mis = 0;
    int wen_total = 0;

    logic [31:0] tb_mem  [256];
    logic [31:0] ref_mem [256];

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .mem_Addr(mem_Addr), .mem_Wd(mem_Wd), .mem_Wen(mem_Wen), .mem_Ren(mem_Ren),
        .mem_Rd(mem_Rd), .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // word-wide memory with one-cycle synchronous read
    always @(posedge clk) begin
        if (mem_Wen && mem_Addr < 32'd256) tb_mem[mem_Addr[7:0]] <= mem_Wd;
        if (mem_Ren && mem_Addr < 32'd256) mem_Rd <= tb_mem[mem_Addr[7:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_Wen) wen_total++;
        check_eq("wen_ren_excl", {31'd0, mem_Wen && mem_Ren}, 32'd0);
        assert (!(mem_Wen && mem_Ren));
        assert (!(req_ready && (mem_Wen || mem_Ren || rsp_valid)));
    end

    // reference model: expected response, memory effect and timing for one request
    task automatic ref_model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] exp_rd,
                             output logic exp_err, output logic [31:0] exp_word,
                             output int exp_lat, output int exp_ren_at, output int exp_wen_at);
        int size;
        int idx;
        int sh;
        logic legal;
        longint unsigned mask, w64, val;
        size  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        idx   = int'(addr / 4);
        exp_err = !legal || (addr % size != 0) || (addr / 4 >= 256);
        exp_rd = 32'd0;
        exp_word = 32'd0;
        exp_ren_at = 0;
        exp_wen_at = 0;
        if (exp_err) begin
            exp_lat = 1;
            return;
        end
        sh   = 8 * int'(addr % 4);
        mask = (64'd1 << (8 * size)) - 64'd1;
        w64  = {32'd0, ref_mem[idx]};
        if (!we) begin
            val = (w64 >> sh) & mask;
            if (!f3[2] && size < 4 && ((val >> (8 * size - 1)) & 64'd1) != 0) val = val | ~mask;
            exp_rd = val[31:0];
            exp_lat = 3;
            exp_ren_at = 1;
        end else begin
            val = (w64 & ~(mask << sh)) | (({32'd0, wd} & mask) << sh);
            exp_word = val[31:0];
            ref_mem[idx] = exp_word;
            exp_lat = (size == 4) ? 2 : 4;
            exp_ren_at = (size == 4) ? 0 : 1;
            exp_wen_at = (size == 4) ? 1 : 3;
        end
    endtask

    // driver: issue one request and follow it to its response, with junk on the inputs meanwhile
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] got);
        logic [31:0] exp_rd, exp_word;
        logic exp_err, got_err;
        int exp_lat, exp_ren_at, exp_wen_at;
        int lat, ren_at, wen_at, ren_cnt, wen_cnt;
        ref_model(we, f3, addr, wd, exp_rd, exp_err, exp_word, exp_lat, exp_ren_at, exp_wen_at);
        lat = 0; ren_at = 0; wen_at = 0; ren_cnt = 0; wen_cnt = 0;
        got = 32'hx; got_err = 1'bx;
        @(negedge clk);
        check_eq("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_we     = 1'($urandom_range(0, 1));
            req_funct3 = 3'($urandom_range(0, 7));
            req_addr   = $urandom;
            req_wdata  = $urandom;
            @(negedge clk);
            if (mem_Ren) begin
                ren_cnt++; ren_at = k;
                check_eq("ren_addr", mem_Addr, addr >> 2);
            end
            if (mem_Wen) begin
                wen_cnt++; wen_at = k;
                check_eq("wen_addr", mem_Addr, addr >> 2);
                check_eq("wen_data", mem_Wd, exp_word);
            end
            if (rsp_valid) begin
                lat = k; got = rsp_rdata; got_err = rsp_error;
            end else begin
                check_eq("ready_busy", {31'd0, req_ready}, 32'd0);
            end
        end
        req_valid = 1'b0;
        check_eq("latency", lat, exp_lat);
        check_eq("rsp_error", {31'd0, got_err}, {31'd0, exp_err});
        check_eq("rsp_rdata", got, exp_rd);
        check_eq("ren_count", ren_cnt, (exp_ren_at != 0) ? 1 : 0);
        check_eq("wen_count", wen_cnt, (exp_wen_at != 0) ? 1 : 0);
        check_eq("ren_cycle", ren_at, exp_ren_at);
        check_eq("wen_cycle", wen_at, exp_wen_at);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] addr;
        int wen_before;
        for (int i = 0; i < 256; i++) begin
            r = $urandom;
            tb_mem[i] = r;
            ref_mem[i] = r;
        end
        mem_Rd = 32'd0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        #12;
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        check_eq("rst_wen", {31'd0, mem_Wen}, 32'd0);
        check_eq("rst_ren", {31'd0, mem_Ren}, 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'd0);
        check_eq("rst_addr", mem_Addr, 32'd0);
        check_eq("rst_wd", mem_Wd, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed cases
        do_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, r);
        do_op(1'b0, 3'b010, 32'h10, 32'h0, r);  check_eq("tp_lw", r, 32'hDEADBEEF);
        do_op(1'b0, 3'b000, 32'h13, 32'h0, r);  check_eq("tp_lb", r, 32'hFFFFFFDE);
        do_op(1'b0, 3'b100, 32'h13, 32'h0, r);  check_eq("tp_lbu", r, 32'h000000DE);
        do_op(1'b0, 3'b001, 32'h10, 32'h0, r);  check_eq("tp_lh", r, 32'hFFFFBEEF);
        do_op(1'b0, 3'b101, 32'h12, 32'h0, r);  check_eq("tp_lhu", r, 32'h0000DEAD);
        do_op(1'b1, 3'b000, 32'h11, 32'h12345678, r);
        check_eq("tp_sb_word", tb_mem[4], 32'hDEAD78EF);
        do_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, r);
        do_op(1'b1, 3'b001, 32'h12, 32'hAAAA5555, r);
        check_eq("tp_sh_word", tb_mem[4], 32'h5555BEEF);
        do_op(1'b0, 3'b010, 32'h02, 32'h0, r);
        do_op(1'b1, 3'b001, 32'h01, 32'h0, r);
        do_op(1'b1, 3'b100, 32'h20, 32'h0, r);
        do_op(1'b0, 3'b010, 32'h400, 32'h0, r);
        do_op(1'b0, 3'b010, 32'h3FC, 32'h0, r);
        do_op(1'b1, 3'b000, 32'h3FF, 32'h5A, r);

        // reset during the MERGE cycle of an SB
        wen_before = wen_total;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h21; req_wdata = 32'hFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("abort_wen", {31'd0, mem_Wen}, 32'd0);
        check_eq("abort_ren", {31'd0, mem_Ren}, 32'd0);
        check_eq("abort_rsp", {31'd0, rsp_valid}, 32'd0);
        check_eq("abort_wd", mem_Wd, 32'd0);
        check_eq("abort_addr", mem_Addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        check_eq("abort_ready", {31'd0, req_ready}, 32'd1);
        check_eq("abort_no_wen", wen_total, wen_before);
        check_eq("abort_word", tb_mem[8], ref_mem[8]);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            addr = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 1100));
            do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom, r);
        end

        for (int i = 0; i < 256; i++) check_eq("final_mem", tb_mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
